// File: rtl/tis_pkg.sv
// Shared word type, value range and saturation helper for the node grid,
// plus the state encoding of the io_port write-acknowledge one-shot.
package tis_pkg;

    typedef logic signed [10:0] tis_word_t;

    localparam tis_word_t TIS_MAX = 11'sd999;
    localparam tis_word_t TIS_MIN = -11'sd999;

    typedef enum logic {
        WR_IDLE = 1'b0,
        WR_ACK  = 1'b1
    } wr_state_t;

    // Clamp a raw 11-bit host value into the legal node range.
    function automatic tis_word_t tis_sat(input logic signed [10:0] value);
        tis_word_t result;
        result = value;
        if (value > TIS_MAX) begin
            result = TIS_MAX;
        end else if (value < TIS_MIN) begin
            result = TIS_MIN;
        end
        return result;
    endfunction

endpackage

// File: rtl/io_fifo.sv
// Synchronous FIFO of tis words; head reads the register file at the read
// pointer so a pushed word is visible right after its push edge.
module io_fifo
    import tis_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic signed [10:0]       wdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic signed [10:0]       head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW-1:0] rd_ptr_next;
    logic [AW:0]   count_reg;
    logic [AW:0]   count_next;
    tis_word_t     mem_reg [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign full    = (count_reg == FULL_CNT);
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    // Guarded here so callers cannot overflow or underflow the pointers.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = empty ? '0 : mem_reg[rd_ptr_reg];

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (do_push) begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= wdata;
        end
    end

endmodule

// File: rtl/io_port.sv
// Grid-edge I/O endpoint: host->node IN FIFO with input saturation and a
// node->host OUT FIFO with a one-cycle write ack. IO_PORT_STATS_EN adds counters.
module io_port
    import tis_pkg::*;
#(
    parameter int IN_DEPTH  = 8,
    parameter int OUT_DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst,
`ifdef IO_PORT_STATS_EN
    input  logic               st_clr,
    output logic [15:0]        st_in_cnt,
    output logic [15:0]        st_out_cnt,
`endif
    input  logic               h_in_valid,
    input  logic signed [10:0] h_in_data,
    output logic               h_in_ready,
    output logic               h_out_valid,
    output logic signed [10:0] h_out_data,
    input  logic               h_out_ready,
    output logic               n_rready,
    output logic signed [10:0] n_data,
    input  logic               n_read,
    input  logic signed [10:0] n_out,
    input  logic               n_write,
    output logic               n_wready
);

    logic                          in_full;
    logic                          in_empty;
    logic                          in_push;
    logic                          in_pop;
    logic [$clog2(IN_DEPTH):0]     in_count_unused;
    tis_word_t                     in_head;
    tis_word_t                     in_wdata;

    logic                          out_full;
    logic                          out_empty;
    logic                          out_push;
    logic                          out_pop;
    logic [$clog2(OUT_DEPTH):0]    out_count_unused;
    tis_word_t                     out_head;

    wr_state_t                     wr_state_reg;
    wr_state_t                     wr_state_next;

    // Host -> node
    assign in_wdata   = tis_sat(h_in_data);
    assign in_push    = h_in_valid && !in_full;
    assign in_pop     = n_read && !in_empty;
    assign h_in_ready = !in_full;
    assign n_rready   = !in_empty;
    assign n_data     = in_head;

    io_fifo #(
        .DEPTH (IN_DEPTH)
    ) u_in_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_push),
        .pop   (in_pop),
        .wdata (in_wdata),
        .full  (in_full),
        .empty (in_empty),
        .count (in_count_unused),
        .head  (in_head)
    );

    // Node -> host. The ack state blocks a second capture while the node
    // is still holding n_write during the ack cycle.
    always_comb begin
        wr_state_next = WR_IDLE;
        out_push      = 1'b0;
        case (wr_state_reg)
            WR_IDLE: begin
                if (n_write && !out_full) begin
                    out_push      = 1'b1;
                    wr_state_next = WR_ACK;
                end
            end
            WR_ACK: begin
                wr_state_next = WR_IDLE;
            end
            default: begin
                wr_state_next = WR_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_reg <= WR_IDLE;
        end else begin
            wr_state_reg <= wr_state_next;
        end
    end

    assign n_wready    = (wr_state_reg == WR_ACK);
    assign out_pop     = h_out_ready && !out_empty;
    assign h_out_valid = !out_empty;
    assign h_out_data  = out_head;

    io_fifo #(
        .DEPTH (OUT_DEPTH)
    ) u_out_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (out_push),
        .pop   (out_pop),
        .wdata (n_out),
        .full  (out_full),
        .empty (out_empty),
        .count (out_count_unused),
        .head  (out_head)
    );

`ifdef IO_PORT_STATS_EN
    logic [1:0]       st_inc;
    logic [1:0][15:0] st_cnt;

    // Index 0 counts completed node reads, index 1 completed node writes.
    assign st_inc = {out_push, in_pop};

    for (genvar gi = 0; gi < 2; gi++) begin : g_stat
        logic [15:0] cnt_reg;
        logic [15:0] cnt_next;

        always_comb begin
            cnt_next = cnt_reg;
            if (st_clr) begin
                cnt_next = '0;
            end else if (st_inc[gi] && (cnt_reg != 16'hFFFF)) begin
                cnt_next = cnt_reg + 16'd1;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_next;
            end
        end

        assign st_cnt[gi] = cnt_reg;
    end

    assign st_in_cnt  = st_cnt[0];
    assign st_out_cnt = st_cnt[1];
`endif

endmodule

// File: tb/tb_io_port.sv
// Directed self-checking bench for io_port: host/node transfers, saturation,
// ack one-shot, full-FIFO stalls and mid-transfer reset.
module tb_io_port;

    logic               clk;
    logic               rst;
    logic               h_in_valid;
    logic signed [10:0] h_in_data;
    logic               h_in_ready;
    logic               h_out_valid;
    logic signed [10:0] h_out_data;
    logic               h_out_ready;
    logic               n_rready;
    logic signed [10:0] n_data;
    logic               n_read;
    logic signed [10:0] n_out;
    logic               n_write;
    logic               n_wready;
`ifdef IO_PORT_STATS_EN
    logic               st_clr;
    logic [15:0]        st_in_cnt;
    logic [15:0]        st_out_cnt;
`endif

    int n_checks = 0;
    int n_bad    = 0;

    io_port #(
        .IN_DEPTH  (8),
        .OUT_DEPTH (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef IO_PORT_STATS_EN
        .st_clr      (st_clr),
        .st_in_cnt   (st_in_cnt),
        .st_out_cnt  (st_out_cnt),
`endif
        .h_in_valid  (h_in_valid),
        .h_in_data   (h_in_data),
        .h_in_ready  (h_in_ready),
        .h_out_valid (h_out_valid),
        .h_out_data  (h_out_data),
        .h_out_ready (h_out_ready),
        .n_rready    (n_rready),
        .n_data      (n_data),
        .n_read      (n_read),
        .n_out       (n_out),
        .n_write     (n_write),
        .n_wready    (n_wready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic host_push(input logic signed [10:0] v);
        h_in_valid = 1'b1;
        h_in_data  = v;
        step();
        h_in_valid = 1'b0;
    endtask

    // Offer v and keep n_write high until the ack is seen (bounded).
    task automatic node_write(input logic signed [10:0] v);
        int waited;
        n_out   = v;
        n_write = 1'b1;
        waited  = 0;
        step();
        while (!n_wready && waited < 20) begin
            step();
            waited++;
        end
        if (!n_wready) begin
            check_val("node_write_ack_timeout", 0, 1);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_h_in_ready"}, int'(h_in_ready), 1);
        check_val({tag, "_h_out_valid"}, int'(h_out_valid), 0);
        check_val({tag, "_n_rready"}, int'(n_rready), 0);
        check_val({tag, "_n_wready"}, int'(n_wready), 0);
        check_val({tag, "_n_data"}, int'(n_data), 0);
        check_val({tag, "_h_out_data"}, int'(h_out_data), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        h_in_valid  = 1'b0;
        h_in_data   = '0;
        h_out_ready = 1'b0;
        n_read      = 1'b0;
        n_out       = '0;
        n_write     = 1'b0;
`ifdef IO_PORT_STATS_EN
        st_clr      = 1'b0;
`endif
        step();
        step();
        check_reset_outputs("reset");
`ifdef IO_PORT_STATS_EN
        check_val("reset_st_in", int'(st_in_cnt), 0);
        check_val("reset_st_out", int'(st_out_cnt), 0);
`endif
        rst = 1'b0;
        step();

        // 1: in-order delivery to the node
        host_push(11'sd5);
        host_push(-11'sd7);
        host_push(11'sd999);
        check_val("t1_rready", int'(n_rready), 1);
        check_val("t1_data0", int'(n_data), 5);
        n_read = 1'b1;
        step();
        check_val("t1_data1", int'(n_data), -7);
        step();
        check_val("t1_data2", int'(n_data), 999);
        step();
        n_read = 1'b0;
        check_val("t1_rready_low", int'(n_rready), 0);
        check_val("t1_data_empty", int'(n_data), 0);
        n_read = 1'b1;
        step();
        n_read = 1'b0;
        check_val("t1_read_empty_ignored", int'(n_rready), 0);

        // 2: saturation on the host path
        host_push(11'sd1023);
        host_push(-11'sd1024);
        check_val("t2_sat_hi", int'(n_data), 999);
        n_read = 1'b1;
        step();
        check_val("t2_sat_lo", int'(n_data), -999);
        step();
        n_read = 1'b0;
        check_val("t2_empty", int'(n_rready), 0);
`ifdef IO_PORT_STATS_EN
        check_val("t2_st_in", int'(st_in_cnt), 5);
`endif

        // 3: held n_write through the ack cycle gives one capture
        n_out   = 11'sd42;
        n_write = 1'b1;
        check_val("t3_no_ack_yet", int'(n_wready), 0);
        step();
        check_val("t3_ack", int'(n_wready), 1);
        check_val("t3_out_valid", int'(h_out_valid), 1);
        check_val("t3_out_data", int'(h_out_data), 42);
        step();
        n_write = 1'b0;
        check_val("t3_ack_one_cycle", int'(n_wready), 0);
        step();
        check_val("t3_ack_stays_low", int'(n_wready), 0);
        h_out_ready = 1'b1;
        step();
        h_out_ready = 1'b0;
        check_val("t3_single_capture", int'(h_out_valid), 0);

        // 4: OUT FIFO full stalls the node until the host pops
        for (int i = 0; i < 8; i++) begin
            node_write(11'(100 + i));
        end
        n_write = 1'b0;
        step();
        check_val("t4_full_head", int'(h_out_data), 100);
        n_out   = 11'sd200;
        n_write = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("t4_stall_no_ack", int'(n_wready), 0);
        end
        h_out_ready = 1'b1;
        step();
        h_out_ready = 1'b0;
        check_val("t4_deferred_no_ack", int'(n_wready), 0);
        check_val("t4_head_after_pop", int'(h_out_data), 101);
        step();
        n_write = 1'b0;
        check_val("t4_late_ack", int'(n_wready), 1);
        h_out_ready = 1'b1;
        for (int i = 1; i < 8; i++) begin
            check_val("t4_drain", int'(h_out_data), 100 + i);
            step();
        end
        check_val("t4_drain_last", int'(h_out_data), 200);
        step();
        h_out_ready = 1'b0;
        check_val("t4_drained", int'(h_out_valid), 0);
`ifdef IO_PORT_STATS_EN
        check_val("t4_st_out", int'(st_out_cnt), 10);
        st_clr = 1'b1;
        n_out  = 11'sd9;
        n_write = 1'b1;
        step();
        st_clr  = 1'b0;
        n_write = 1'b0;
        check_val("st_clr_in", int'(st_in_cnt), 0);
        check_val("st_clr_out_priority", int'(st_out_cnt), 0);
        h_out_ready = 1'b1;
        step();
        h_out_ready = 1'b0;
`endif

        // 5: full IN FIFO with push and pop together pops only
        for (int i = 1; i <= 8; i++) begin
            host_push(11'(i));
        end
        check_val("t5_full_not_ready", int'(h_in_ready), 0);
        check_val("t5_head", int'(n_data), 1);
        h_in_valid = 1'b1;
        h_in_data  = 11'sd77;
        n_read     = 1'b1;
        step();
        h_in_valid = 1'b0;
        check_val("t5_ready_again", int'(h_in_ready), 1);
        for (int i = 2; i <= 8; i++) begin
            check_val("t5_drain", int'(n_data), i);
            step();
        end
        n_read = 1'b0;
        check_val("t5_no_extra_word", int'(n_rready), 0);

        // 6: reset while both FIFOs hold data and a write is pending
        for (int i = 0; i < 4; i++) begin
            host_push(11'(10 + i));
        end
        for (int i = 0; i < 4; i++) begin
            node_write(11'(20 + i));
        end
        n_write = 1'b0;
        step();
        check_val("t6_in_half", int'(n_data), 10);
        check_val("t6_out_half", int'(h_out_data), 20);
        n_out   = 11'sd55;
        n_write = 1'b1;
        rst     = 1'b1;
        step();
        check_reset_outputs("t6_rst");
        rst     = 1'b0;
        n_write = 1'b0;
        step();
        check_val("t6_no_ack_after", int'(n_wready), 0);
        check_val("t6_out_empty", int'(h_out_valid), 0);
        check_val("t6_in_empty", int'(n_rready), 0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
